// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: base opcodes, fetch states, reset PC.
package riscv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC register: redirect load has priority over the sequential +4 step.
module ifu_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM (REQ -> WAIT -> HOLD).
// Define MISALIGN_CHECK_EN to reject misaligned redirects and flag misalign_err.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam logic [1:0] S_REQ  = FETCH_REQ;
    localparam logic [1:0] S_WAIT = FETCH_WAIT;
    localparam logic [1:0] S_HOLD = FETCH_HOLD;

    logic [1:0]  state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        redir;
    logic [31:0] redir_target;
    logic        pc_inc;
    logic [31:0] pc;

`ifdef MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redir        = redirect_valid && word_aligned(redirect_pc);
    assign redir_target = redirect_pc;

    always_comb begin
        misalign_d = redirect_valid && !word_aligned(redirect_pc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign redir        = redirect_valid;
    assign redir_target = redirect_pc & ~32'd3;
    assign misalign_err = 1'b0;
`endif

    ifu_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redir),
        .load_pc (redir_target),
        .inc     (pc_inc),
        .pc      (pc)
    );

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_inc    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // A redirect racing an accepted request orphans its response.
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redir;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        state_d   = S_HOLD;
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc;
                        pc_inc    = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redir || inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            drop_q    <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign opcode         = inst_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory: one response per accepted request, optionally stalled/late.
    logic        pend;
    logic [31:0] paddr;
    logic        mem_fast, mem_stall, mem_noise;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            paddr <= 32'd0;
        end else begin
            if (imem_rsp_valid && pend) pend <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                pend  <= 1'b1;
                paddr <= imem_addr;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (pend && !mem_stall && (mem_fast || $urandom_range(9) < 6)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(paddr);
        end else if (!pend && mem_noise && $urandom_range(9) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Behavioural model: is a request outstanding, is an instruction held,
    // must the next response be thrown away.
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_out, m_hold, m_drop, m_mis;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] npc, ninst, nipc, tgt;
        logic        nout, nhold, ndrop, eff;
        if (!rst_n) begin
            m_pc   <= 32'd0;
            m_inst <= 32'd0;
            m_ipc  <= 32'd0;
            m_out  <= 1'b0;
            m_hold <= 1'b0;
            m_drop <= 1'b0;
            m_mis  <= 1'b0;
        end else begin
            npc = m_pc; ninst = m_inst; nipc = m_ipc;
            nout = m_out; nhold = m_hold; ndrop = m_drop;
`ifdef MISALIGN_CHECK_EN
            eff = redirect_valid && (redirect_pc % 4 == 0);
            tgt = redirect_pc;
            m_mis <= redirect_valid && (redirect_pc % 4 != 0);
`else
            eff = redirect_valid;
            tgt = redirect_pc - (redirect_pc % 4);
            m_mis <= 1'b0;
`endif
            if (m_hold) begin
                if (eff || inst_ready) nhold = 1'b0;
                if (eff) npc = tgt;
            end else if (!m_out) begin
                if (eff) npc = tgt;
                if (imem_req_ready) begin
                    nout  = 1'b1;
                    ndrop = eff;
                end
            end else begin
                if (eff) begin
                    npc = tgt;
                    if (imem_rsp_valid) begin
                        nout  = 1'b0;
                        ndrop = 1'b0;
                    end else begin
                        ndrop = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    nout = 1'b0;
                    if (m_drop) begin
                        ndrop = 1'b0;
                    end else begin
                        nhold = 1'b1;
                        ninst = imem_rsp_data;
                        nipc  = m_pc;
                        npc   = m_pc + 32'd4;
                    end
                end
            end
            m_pc <= npc; m_inst <= ninst; m_ipc <= nipc;
            m_out <= nout; m_hold <= nhold; m_drop <= ndrop;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_req_valid", {31'd0, imem_req_valid}, {31'd0, !m_out && !m_hold});
            chk("m_addr", imem_addr, m_pc);
            chk("m_inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
            chk("m_inst", inst, m_inst);
            chk("m_inst_pc", inst_pc, m_ipc);
            chk("m_opcode", {25'd0, opcode}, {25'd0, m_inst[6:0]});
            chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
        end
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!imem_req_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, {31'd0, imem_req_valid}, 32'd1);
    endtask

    logic [31:0] exp_stream [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        int k;
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        mem_fast = 1'b1; mem_stall = 1'b0; mem_noise = 1'b0;
        #1;
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;

        // first fetch: accept, 1-cycle response, valid in cycle 3
        tick();
        chk("c2_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("c3_opcode", {25'd0, opcode}, {25'd0, 7'b0010011});
        chk("c3_inst_pc", inst_pc, 32'd0);
        chk("c3_inst", inst, 32'h0050_0093);

        // streaming with decode always ready
        inst_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 20 && k < 4; n++) begin
            if (inst_valid) begin
                chk("stream_pc", inst_pc, exp_stream[k]);
                k++;
            end
            if (k < 4) tick();
        end
        chk("stream_count", k, 32'd4);
        tick();

        // decode stall for 5 cycles
        inst_ready = 1'b0;
        wait_valid("hold");
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_pc", inst_pc, 32'h10);
            chk("hold_inst", inst, word(32'h10));
            chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // redirect while a response is pending
        mem_stall = 1'b1;
        wait_req("redir_pre");
        tick();
        chk("redir_in_wait", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        mem_stall = 1'b0;
        wait_req("redir_req");
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid("redir_valid");
        chk("redir_inst_pc", inst_pc, 32'h100);
        chk("redir_inst", inst, word(32'h100));

        // misaligned redirect while holding
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef MISALIGN_CHECK_EN
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        chk("mis_kept_valid", {31'd0, inst_valid}, 32'd1);
        chk("mis_kept_pc", inst_pc, 32'h100);
        chk("mis_pc_same", imem_addr, 32'h104);
        tick();
        chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
`else
        chk("mis_flush", {31'd0, inst_valid}, 32'd0);
        chk("mis_req", {31'd0, imem_req_valid}, 32'd1);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_no_err", {31'd0, misalign_err}, 32'd0);
        wait_valid("mis_refetch");
        chk("mis_refetch_pc", inst_pc, 32'h100);
`endif

        // PC wrap at the top of the address space
        wait_valid("wrap_pre");
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_valid("wrap");
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wrap_req", {31'd0, imem_req_valid}, 32'd1);
        chk("wrap_addr", imem_addr, 32'd0);

        // reset while waiting for a response
        mem_stall = 1'b1;
        tick();
        chk("rstw_in_wait", {31'd0, imem_req_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rstw_inst", inst, 32'd0);
        chk("rstw_inst_pc", inst_pc, 32'd0);
        chk("rstw_opcode", {25'd0, opcode}, 32'd0);
        chk("rstw_addr", imem_addr, 32'd0);
        chk("rstw_req", {31'd0, imem_req_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_stall = 1'b0;
        wait_valid("rstw_restart");
        chk("rstw_restart_pc", inst_pc, 32'd0);
        chk("rstw_restart_inst", inst, 32'h0050_0093);

        // randomized traffic against the model
        mem_fast = 1'b0;
        mem_noise = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            imem_req_ready = $urandom_range(9) < 7;
            inst_ready = $urandom_range(9) < 6;
            redirect_valid = $urandom_range(15) == 0;
            case ($urandom_range(3))
                0: redirect_pc = $urandom;
                1: redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: redirect_pc = $urandom & 32'h3FC;
            endcase
            tick();
            if ($urandom_range(599) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
